dense_layer: RTL and testbench

//  Parametrised fully-connected layer: y = sat(b + W^T.x), N_OUT outputs from N_IN inputs.

---
 rtl/fxp_pkg.sv | 42 ++++
 rtl/dense_layer_mac_lane.sv | 42 ++++
 rtl/dense_layer.sv | 130 +++++++++++++
 tb/tb_dense_layer.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/fxp_pkg.sv
// Signed fixed-point helpers shared by the dense layer and its MAC lanes:
// default word format, saturation, scaled multiply and the layer FSM states.
package fxp_pkg;

  localparam int BITSIZE = 16;
  localparam int FRAC    = 8;

  // Wide working width for the helper functions; any BITSIZE up to 32 keeps
  // the full product exact inside it.
  localparam int FXP_W = 64;

  typedef logic signed [FXP_W-1:0] fxp_wide_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MAC  = 2'd1,
    OUT  = 2'd2
  } state_t;

  // Full-precision product, then arithmetic shift right by frac.
  // The shift floors toward minus infinity, so -1/256 becomes -1 LSB.
  function automatic fxp_wide_t fxp_mul(input fxp_wide_t a,
                                        input fxp_wide_t b,
                                        input int        frac);
    fxp_wide_t p;
    p = a * b;
    return p >>> frac;
  endfunction

  // Clamp a wide accumulator into a signed word of 'bits' bits.
  function automatic fxp_wide_t fxp_sat(input fxp_wide_t acc,
                                        input int        bits);
    fxp_wide_t max_v;
    fxp_wide_t min_v;
    max_v = (fxp_wide_t'(1) <<< (bits - 1)) - fxp_wide_t'(1);
    min_v = -max_v - fxp_wide_t'(1);
    if (acc > max_v)      return max_v;
    else if (acc < min_v) return min_v;
    else                  return acc;
  endfunction

endpackage

// File: rtl/dense_layer_mac_lane.sv
// One multiply-accumulate lane of the dense layer. Holds only the
// accumulator; the layer top sequences it with clr / init / en.
//   clr  : zero the accumulator
//   init : load the sign-extended word on 'a' (the bias)
//   en   : accumulate fxp_mul(a, wt)
module mac_lane #(
  parameter int BITSIZE = fxp_pkg::BITSIZE,
  parameter int FRAC    = fxp_pkg::FRAC,
  parameter int ACC_W   = BITSIZE + 5
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      clr,
  input  logic                      init,
  input  logic                      en,
  input  logic signed [BITSIZE-1:0] a,
  input  logic signed [BITSIZE-1:0] wt,
  output logic signed [ACC_W-1:0]   acc
);
  import fxp_pkg::*;

  logic signed [ACC_W-1:0] r_acc;
  logic signed [ACC_W-1:0] w_prod;
  logic signed [ACC_W-1:0] w_a_ext;

  // Scaled product and bias, both sign-extended into the accumulator width.
  assign w_prod  = ACC_W'(fxp_mul(FXP_W'(a), FXP_W'(wt), FRAC));
  assign w_a_ext = ACC_W'(a);

  // Accumulator register: clear, bias load or accumulate, in that priority.
  always_ff @(posedge clk) begin
    // NOTE: state is updated with non-blocking assignments so every register
    // samples its inputs from the same edge, independent of statement order.
    if (reset)     r_acc <= '0;
    else if (clr)  r_acc <= '0;
    else if (init) r_acc <= w_a_ext;
    else if (en)   r_acc <= r_acc + w_prod;
  end

  assign acc = r_acc;

endmodule

// File: rtl/dense_layer.sv
// Fully connected layer y = sat(b + W^T.x) in signed Q(BITSIZE-FRAC).FRAC.
// One input element per cycle is fed to N_OUT parallel MAC lanes.
// Sequence: accept (IDLE) -> N_IN MAC cycles -> OUT (y registered, done).
// Build option: define DENSE_RELU_EN to clamp negative outputs to zero.
module dense_layer #(
  parameter int BITSIZE = fxp_pkg::BITSIZE,
  parameter int FRAC    = fxp_pkg::FRAC,
  parameter int N_IN    = 10,
  parameter int N_OUT   = 6
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          start,
  input  logic [BITSIZE*N_IN-1:0]       x,
  input  logic [BITSIZE*N_OUT*N_IN-1:0] w,
  input  logic [BITSIZE*N_OUT-1:0]      b,
  output logic                          busy,
  output logic                          done,
  output logic [BITSIZE*N_OUT-1:0]      y
);
  import fxp_pkg::*;

  localparam int ACC_W = BITSIZE + $clog2(N_IN + 1) + 1;
  localparam int IDX_W = (N_IN > 1) ? $clog2(N_IN) : 1;

  state_t                     r_state;
  logic [IDX_W-1:0]           r_idx;
  logic [BITSIZE*N_IN-1:0]    r_x;
  logic [BITSIZE*N_OUT-1:0]   r_y;
  logic                       r_busy;
  logic                       r_done;

  logic                       w_accept;
  logic                       w_last;
  logic                       w_lane_clr;
  logic                       w_lane_en;
  logic [31:0]                w_idx;
  logic signed [BITSIZE-1:0]  w_x_cur;
  logic [BITSIZE*N_OUT-1:0]   w_y_next;
  logic signed [ACC_W-1:0]    w_acc [N_OUT];

  // A request is taken only from IDLE; start during MAC or OUT is ignored.
  assign w_accept   = (r_state == IDLE) && start;
  assign w_last     = (r_idx == IDX_W'(N_IN - 1));
  assign w_lane_en  = (r_state == MAC);
  // Accumulators are cleared once their result has been moved into y.
  assign w_lane_clr = (r_state == OUT);
  assign w_idx      = 32'(r_idx);
  assign w_x_cur    = r_x[BITSIZE*w_idx +: BITSIZE];

  for (genvar o = 0; o < N_OUT; o++) begin : g_lane
    logic signed [BITSIZE-1:0] w_a;
    logic signed [BITSIZE-1:0] w_wt;
    logic signed [BITSIZE-1:0] w_sat;

    // On the accept edge the lane loads its bias through 'a'; afterwards
    // 'a' carries the captured input element selected by idx.
    assign w_a   = w_accept ? b[BITSIZE*o +: BITSIZE] : w_x_cur;
    // Weights are read live from the port; they are held stable while busy.
    assign w_wt  = w[BITSIZE*(N_OUT*w_idx + o) +: BITSIZE];
    assign w_sat = BITSIZE'(fxp_sat(FXP_W'(w_acc[o]), BITSIZE));

`ifdef DENSE_RELU_EN
    assign w_y_next[BITSIZE*o +: BITSIZE] = w_sat[BITSIZE-1] ? '0 : w_sat;
`else
    assign w_y_next[BITSIZE*o +: BITSIZE] = w_sat;
`endif

    mac_lane #(
      .BITSIZE (BITSIZE),
      .FRAC    (FRAC),
      .ACC_W   (ACC_W)
    ) u_lane (
      .clk   (clk),
      .reset (reset),
      .clr   (w_lane_clr),
      .init  (w_accept),
      .en    (w_lane_en),
      .a     (w_a),
      .wt    (w_wt),
      .acc   (w_acc[o])
    );
  end

  // Layer sequencer: input capture, element index, busy/done and y register.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
      r_idx   <= '0;
      // NOTE: the x capture register is reset along with the rest of the
      // state; it is small, and a known value keeps lane inputs free of X.
      r_x     <= '0;
      r_y     <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (start) begin
            r_x     <= x;
            r_idx   <= '0;
            r_busy  <= 1'b1;
            r_state <= MAC;
          end
        end
        MAC: begin
          if (w_last) begin
            r_idx   <= '0;
            r_busy  <= 1'b0;
            r_state <= OUT;
          end else begin
            r_idx <= r_idx + IDX_W'(1);
          end
        end
        OUT: begin
          r_y     <= w_y_next;
          r_done  <= 1'b1;
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign busy = r_busy;
  assign done = r_done;
  assign y    = r_y;

endmodule

// File: tb/tb_dense_layer.sv
// Directed self-checking bench for dense_layer at BITSIZE=16, FRAC=8,
// N_IN=10, N_OUT=6. Expectations follow DENSE_RELU_EN when it is defined.
module tb_dense_layer;

  localparam int BS = 16;
  localparam int NI = 10;
  localparam int NO = 6;

`ifdef DENSE_RELU_EN
  localparam bit RELU = 1'b1;
`else
  localparam bit RELU = 1'b0;
`endif

  logic               clk = 1'b0;
  logic               reset;
  logic               start;
  logic [BS*NI-1:0]   x;
  logic [BS*NO*NI-1:0] w;
  logic [BS*NO-1:0]   b;
  logic               busy;
  logic               done;
  logic [BS*NO-1:0]   y;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  dense_layer #(
    .BITSIZE (BS),
    .FRAC    (8),
    .N_IN    (NI),
    .N_OUT   (NO)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .x     (x),
    .w     (w),
    .b     (b),
    .busy  (busy),
    .done  (done),
    .y     (y)
  );

  // Uniform stimulus: every x element, every weight and every bias the same.
  task automatic fill(input logic [15:0] xv, input logic [15:0] wv, input logic [15:0] bv);
    for (int i = 0; i < NI; i++) x[BS*i +: BS] = xv;
    for (int k = 0; k < NI*NO; k++) w[BS*k +: BS] = wv;
    for (int o = 0; o < NO; o++) b[BS*o +: BS] = bv;
  endtask

  // Wait (bounded) for done after an accept; lat = edges since accept, 0 on timeout.
  task automatic wait_done(output int lat, inout int busy_cnt);
    lat = 0;
    for (int c = 1; c <= 40; c++) begin
      @(posedge clk); #1;
      if (done) begin
        lat = c;
        break;
      end
      if (busy) busy_cnt++;
    end
  endtask

  // Accept one operation (called 1 time unit after an edge) and wait for done.
  task automatic run_op(output int lat, output int busy_cnt);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    busy_cnt = busy ? 1 : 0;
    wait_done(lat, busy_cnt);
  endtask

  task automatic test_reset;
    reset = 1'b1;
    start = 1'b0;
    fill(16'h0, 16'h0, 16'h0);
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
    checks++;
    if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b want 0", done); end
    checks++;
    if (y !== '0) begin errors++; $display("FAIL reset_y: got %h want 0", y); end
    reset = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_basic;
    int lat, bc;
    fill(16'h0100, 16'h0080, 16'h0000);
    run_op(lat, bc);
    checks++;
    if (lat !== 11) begin errors++; $display("FAIL basic_latency: got %0d want 11", lat); end
    checks++;
    if (bc !== 10) begin errors++; $display("FAIL basic_busy_cycles: got %0d want 10", bc); end
    checks++;
    if (y !== {NO{16'h0500}}) begin errors++; $display("FAIL basic_y: got %h want all 0500", y); end
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL basic_busy_at_done: got %b want 0", busy); end
    @(posedge clk); #1;
    checks++;
    if (done !== 1'b0) begin errors++; $display("FAIL basic_done_pulse_width: got %b want 0", done); end
    checks++;
    if (y !== {NO{16'h0500}}) begin errors++; $display("FAIL basic_y_hold: got %h want all 0500", y); end
  endtask

  task automatic test_saturate;
    int lat, bc;
    logic [15:0] exp_neg;
    fill(16'h7F00, 16'h0100, 16'h7FFF);
    run_op(lat, bc);
    checks++;
    if (lat !== 11 || y !== {NO{16'h7FFF}}) begin
      errors++; $display("FAIL sat_pos: lat %0d y %h want lat 11 y all 7fff", lat, y);
    end
    fill(16'h7F00, 16'hFF00, 16'h7FFF);
    run_op(lat, bc);
    exp_neg = RELU ? 16'h0000 : 16'h8000;
    checks++;
    if (lat !== 11 || y !== {NO{exp_neg}}) begin
      errors++; $display("FAIL sat_neg: lat %0d y %h want lat 11 y all %h", lat, y, exp_neg);
    end
  endtask

  task automatic test_neg_bias;
    int lat, bc;
    logic [15:0] exp_v;
    fill(16'h0100, 16'h0000, 16'hFF80);
    run_op(lat, bc);
    exp_v = RELU ? 16'h0000 : 16'hFF80;
    checks++;
    if (y !== {NO{exp_v}}) begin errors++; $display("FAIL neg_bias: got %h want all %h", y, exp_v); end
  endtask

  task automatic test_floor;
    int lat, bc;
    logic [15:0] exp_v;
    fill(16'h0000, 16'h0000, 16'h0000);
    x[15:0] = 16'hFFFF;
    for (int o = 0; o < NO; o++) w[BS*o +: BS] = 16'h0001;
    run_op(lat, bc);
    exp_v = RELU ? 16'h0000 : 16'hFFFF;
    checks++;
    if (y !== {NO{exp_v}}) begin errors++; $display("FAIL floor_neg: got %h want all %h", y, exp_v); end
    x[15:0] = 16'h0001;
    run_op(lat, bc);
    checks++;
    if (y !== {NO{16'h0000}}) begin errors++; $display("FAIL floor_pos: got %h want all 0000", y); end
  endtask

  // Distinct weights per lane and values per element; x and b are scrambled
  // after accept and must not affect the result.
  task automatic test_lanes;
    int lat, bc;
    logic [BS*NO-1:0] exp_y;
    for (int i = 0; i < NI; i++) x[BS*i +: BS] = 16'(256 * (i + 1));
    for (int i = 0; i < NI; i++)
      for (int o = 0; o < NO; o++) w[BS*(NO*i + o) +: BS] = 16'(16 * (o + 1));
    for (int o = 0; o < NO; o++) b[BS*o +: BS] = 16'(256 * o);
    // sum_i 256(i+1)*16(o+1)/256 = 16*55*(o+1) = 880(o+1), plus bias 256*o
    for (int o = 0; o < NO; o++) exp_y[BS*o +: BS] = 16'(880 * (o + 1) + 256 * o);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    x = ~x;
    b = ~b;
    bc = 0;
    wait_done(lat, bc);
    checks++;
    if (lat !== 11 || y !== exp_y) begin
      errors++; $display("FAIL lanes: lat %0d y %h want lat 11 y %h", lat, y, exp_y);
    end
  endtask

  task automatic test_back_to_back;
    int third;
    fill(16'h0100, 16'h0080, 16'h0000);
    start = 1'b1;
    for (int c = 0; c <= 30; c++) begin
      @(posedge clk); #1;
      checks++;
      if (done !== ((c == 11) || (c == 23))) begin
        errors++; $display("FAIL b2b_done_c%0d: got %b want %b", c, done, (c == 11) || (c == 23));
      end
      if (c == 12 || c == 24) begin
        checks++;
        if (busy !== 1'b1) begin errors++; $display("FAIL b2b_accept_c%0d: busy %b want 1", c, busy); end
      end
    end
    start = 1'b0;
    third = 0;
    for (int c = 31; c <= 45; c++) begin
      @(posedge clk); #1;
      if (done) begin third = c; break; end
    end
    checks++;
    if (third !== 35) begin errors++; $display("FAIL b2b_third_done: at %0d want 35", third); end
    checks++;
    if (y !== {NO{16'h0500}}) begin errors++; $display("FAIL b2b_y: got %h want all 0500", y); end
  endtask

  task automatic test_busy_ignore;
    int n_done, first;
    fill(16'h0100, 16'h0080, 16'h0000);
    start = 1'b1;
    @(posedge clk); #1;
    n_done = 0;
    first = 0;
    for (int c = 1; c <= 30; c++) begin
      start = (c == 3) || (c == 7);
      @(posedge clk); #1;
      if (done) begin
        n_done++;
        if (first == 0) first = c;
      end
    end
    start = 1'b0;
    checks++;
    if (n_done !== 1 || first !== 11) begin
      errors++; $display("FAIL busy_ignore: %0d done pulses first at %0d want 1 at 11", n_done, first);
    end
  endtask

  task automatic test_reset_abort;
    int lat, bc, n_done;
    fill(16'h0100, 16'h0080, 16'h0000);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || y !== '0) begin
      errors++; $display("FAIL abort_state: busy %b done %b y %h want 0 0 0", busy, done, y);
    end
    reset = 1'b0;
    n_done = 0;
    for (int c = 0; c < 15; c++) begin
      @(posedge clk); #1;
      if (done) n_done++;
    end
    checks++;
    if (n_done !== 0) begin errors++; $display("FAIL abort_no_done: %0d pulses want 0", n_done); end
    run_op(lat, bc);
    checks++;
    if (lat !== 11 || bc !== 10 || y !== {NO{16'h0500}}) begin
      errors++; $display("FAIL abort_restart: lat %0d busy %0d y %h want 11 10 all 0500", lat, bc, y);
    end
  endtask

  initial begin
    reset = 1'b1;
    start = 1'b0;
    x = '0;
    w = '0;
    b = '0;
    test_reset();
    test_basic();
    test_saturate();
    test_neg_bias();
    test_floor();
    test_lanes();
    test_back_to_back();
    test_busy_ignore();
    test_reset_abort();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
